rk8e_dbreak: RTL and testbench

Data-break (DMA) sequencer directly downstream of the RK8E controller. It takes single-word break requests (address, direction, write data) and waits for a CPU major-state boundary. It then stalls the CPU, runs one memory read or write cycle and returns read data plus a one-cycle DB1 strobe, which the controller uses to drop its request. It also keeps a transferred-word count and a sticky "data request late" flag, which maps to RK8E status bit 9.

---
 rtl/rk8e_dbreak_pkg.sv | 19 +
 rtl/rk8e_dbreak_if.sv | 41 ++++
 rtl/rk8e_dbreak.sv | 126 ++++++++++++
 tb/tb_rk8e_dbreak.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rk8e_dbreak_pkg.sv
// Shared types for the RK8E data-break sequencer.
// State encoding, PDP-8 address/word types and default timing.
package sd_types;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        CYCLE,
        WAIT,
        ACK
    } dbstate_t;

    typedef logic [0:14] addr_t;
    typedef logic [0:11] word_t;

    localparam int MEM_RD_LAT_DEF   = 2;
    localparam int SYNC_TIMEOUT_DEF = 64;

endpackage

// File: rtl/rk8e_dbreak_if.sv
// Controller, CPU and memory signals of the data-break sequencer.
// slave is the sequencer's view, master the surrounding system's.
interface rk8e_dbreak_if;
    import sd_types::*;

    logic  clear;
    logic  db_req;
    logic  db_to_disk;
    addr_t db_addr;
    word_t db_wdata;
    word_t db_rdata;
    logic  db1;
    logic  db_ack;
    logic  break_in_prog;
    logic  cpu_boundary;
    addr_t mem_addr;
    word_t mem_wdata;
    logic  mem_we;
    logic  mem_re;
    word_t mem_rdata;
    word_t xfer_cnt;
    logic  cnt_wrap;
    logic  db_late;

    modport slave (
        input  clear, db_req, db_to_disk, db_addr, db_wdata,
        input  cpu_boundary, mem_rdata,
        output db_rdata, db1, db_ack, break_in_prog,
        output mem_addr, mem_wdata, mem_we, mem_re,
        output xfer_cnt, cnt_wrap, db_late
    );

    modport master (
        output clear, db_req, db_to_disk, db_addr, db_wdata,
        output cpu_boundary, mem_rdata,
        input  db_rdata, db1, db_ack, break_in_prog,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        input  xfer_cnt, cnt_wrap, db_late
    );

endinterface

// File: rtl/rk8e_dbreak.sv
// RK8E data-break sequencer: waits for a CPU boundary, steals one
// memory cycle, returns read data and keeps a transfer count.
module rk8e_dbreak
    import sd_types::*;
#(
    parameter int MEM_RD_LAT   = MEM_RD_LAT_DEF,
    parameter int SYNC_TIMEOUT = SYNC_TIMEOUT_DEF
) (
    input logic         clk,
    input logic         reset,
    rk8e_dbreak_if.slave bus
);

    localparam logic [7:0] TMO_LAST = 8'(SYNC_TIMEOUT - 1);
    localparam logic [2:0] LAT_LAST = 3'(MEM_RD_LAT - 1);

    dbstate_t   state, next_state;
    logic       armed;
    logic       abort;
    logic       lat_to_disk;
    addr_t      lat_addr;
    word_t      lat_wdata;
    logic [7:0] tcnt;
    logic [2:0] lcnt;
    word_t      rdata_q;
    word_t      cnt_q;
    logic       late_q;
    logic       tmo;
    logic       lat_done;
    logic       take;

    assign tmo      = (tcnt == TMO_LAST);
    assign lat_done = (lcnt == LAT_LAST);
    assign take     = (state == IDLE) && !bus.clear
                   && bus.db_req && armed;

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:  if (take) next_state = SYNC;
            SYNC: begin
                if (bus.clear || !bus.db_req)
                    next_state = IDLE;
                else if (bus.cpu_boundary || tmo)
                    next_state = CYCLE;
            end
            CYCLE: begin
                if (lat_to_disk)    next_state = WAIT;
                else if (bus.clear) next_state = IDLE;
                else                next_state = ACK;
            end
            WAIT: begin
                if (lat_done)
                    next_state = (abort || bus.clear) ? IDLE : ACK;
            end
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Strobes decode straight from state so reset drops them at once.
    assign bus.db1           = (state == CYCLE);
    assign bus.mem_we        = (state == CYCLE) && !lat_to_disk;
    assign bus.mem_re        = (state == CYCLE) && lat_to_disk;
    assign bus.db_ack        = (state == ACK) && !bus.clear;
    assign bus.cnt_wrap      = bus.db_ack && (cnt_q == 12'o7777);
    assign bus.break_in_prog = (state == CYCLE) || (state == WAIT)
                            || (state == ACK);
    assign bus.mem_addr      = lat_addr;
    assign bus.mem_wdata     = lat_wdata;
    assign bus.db_rdata      = rdata_q;
    assign bus.xfer_cnt      = cnt_q;
    assign bus.db_late       = late_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            armed       <= 1'b1;
            abort       <= 1'b0;
            lat_to_disk <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            tcnt        <= '0;
            lcnt        <= '0;
            rdata_q     <= '0;
            cnt_q       <= '0;
            late_q      <= 1'b0;
        end else begin
            state <= next_state;
            tcnt  <= (state == SYNC) ? tcnt + 8'd1 : 8'd0;
            lcnt  <= (state == WAIT) ? lcnt + 3'd1 : 3'd0;

            if (take) begin
                lat_to_disk <= bus.db_to_disk;
                lat_addr    <= bus.db_addr;
                lat_wdata   <= bus.db_wdata;
            end

            // A held request must go low before it can be served again.
            if (bus.clear || take)
                armed <= 1'b0;
            else if (!bus.db_req && (state == IDLE || state == ACK))
                armed <= 1'b1;

            if (state == IDLE)
                abort <= 1'b0;
            else if (bus.clear && (state == CYCLE || state == WAIT))
                abort <= 1'b1;

            if (state == WAIT && lat_done)
                rdata_q <= bus.mem_rdata;

            if (bus.clear)
                late_q <= 1'b0;
            else if (state == SYNC && bus.db_req && tmo
                     && !bus.cpu_boundary)
                late_q <= 1'b1;

            if (bus.clear)
                cnt_q <= '0;
            else if (state == ACK)
                cnt_q <= cnt_q + 12'd1;
        end
    end

endmodule

// File: tb/tb_rk8e_dbreak.sv
// Scoreboard bench for rk8e_dbreak: stimulus queues expected strobes
// and acks, negedge monitors pop and compare them.
module tb_rk8e_dbreak;
    import sd_types::*;

    localparam int LAT = 2;
    localparam int TMO = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rk8e_dbreak_if bus ();

    rk8e_dbreak #(
        .MEM_RD_LAT  (LAT),
        .SYNC_TIMEOUT(TMO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic  we;
        logic  re;
        addr_t a;
        word_t d;
    } mexp_t;

    typedef struct {
        int    c;
        logic  rd;
        word_t d;
        logic  wrap;
    } aexp_t;

    mexp_t mq[$];
    aexp_t aq[$];

    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    int    acks = 0;
    int    wraps = 0;
    int    strobes = 0;
    int    bip_cnt = 0;
    word_t exp_cnt = '0;

    logic [11:0] mem [0:32767];
    word_t       pipe [0:LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory returns data exactly LAT clocks after the mem_re clock.
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        pipe[0] <= bus.mem_re ? mem[bus.mem_addr] : 12'o7777;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.mem_rdata = pipe[LAT-1];

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0o want %0o", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        mexp_t m;
        aexp_t x;
        if (!reset) begin
            if (bus.db1 || bus.mem_we || bus.mem_re) begin
                strobes++;
                if (mq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL mem_strobe: got db1=%b we=%b re=%b want none",
                             bus.db1, bus.mem_we, bus.mem_re);
                end else begin
                    m = mq.pop_front();
                    chk("db1", bus.db1, 1);
                    chk("mem_we", bus.mem_we, m.we);
                    chk("mem_re", bus.mem_re, m.re);
                    chk("mem_addr", bus.mem_addr, m.a);
                    if (m.we) chk("mem_wdata", bus.mem_wdata, m.d);
                end
            end
            if (bus.break_in_prog) bip_cnt++;
            if (bus.cnt_wrap) wraps++;
            if (bus.db_ack) begin
                acks++;
                if (aq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL db_ack: got ack at cycle %0d want none", cyc);
                end else begin
                    x = aq.pop_front();
                    chk("ack_cycle", cyc, x.c);
                    if (x.rd) chk("db_rdata", bus.db_rdata, x.d);
                    chk("cnt_wrap", bus.cnt_wrap, x.wrap);
                end
            end
        end
    end

    task automatic wait_ack(input int a0);
        for (int i = 0; i < 400 && acks == a0; i++) @(negedge clk);
        if (acks == a0) begin
            tests++;
            fails++;
            $display("FAIL ack_timeout: got no ack want one");
        end
    endtask

    // stall: clocks with cpu_boundary low after SYNC entry; <0 never high.
    task automatic xfer(input logic rd, input addr_t a, input word_t d,
                        input word_t rexp, input int stall,
                        input bit hold);
        int    t0;
        int    a0;
        int    s0;
        mexp_t m;
        aexp_t x;
        @(posedge clk);
        #1;
        bus.db_to_disk   = rd;
        bus.db_addr      = a;
        bus.db_wdata     = d;
        bus.cpu_boundary = (stall == 0);
        bus.db_req       = 1'b1;
        t0 = cyc;
        a0 = acks;
        s0 = strobes;
        m.we = !rd;
        m.re = rd;
        m.a  = a;
        m.d  = d;
        mq.push_back(m);
        x.c    = t0 + 3 + (rd ? LAT : 0) + ((stall < 0) ? TMO - 1 : stall);
        x.rd   = rd;
        x.d    = rexp;
        x.wrap = (exp_cnt == 12'o7777);
        aq.push_back(x);
        exp_cnt = exp_cnt + 12'd1;
        if (stall > 0) begin
            repeat (stall + 1) @(posedge clk);
            #1;
            chk("stall_no_strobe", strobes - s0, 0);
            chk("stall_late", bus.db_late, 0);
            bus.cpu_boundary = 1'b1;
        end
        wait_ack(a0);
        if (hold) begin
            repeat (20) @(posedge clk);
            chk("held_one_ack", acks - a0, 1);
        end
        @(posedge clk);
        #1;
        bus.db_req       = 1'b0;
        bus.cpu_boundary = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int    b0;
        int    a0;
        int    w0;
        mexp_t m;
        aexp_t x;

        bus.clear        = 1'b0;
        bus.db_req       = 1'b0;
        bus.db_to_disk   = 1'b0;
        bus.db_addr      = '0;
        bus.db_wdata     = '0;
        bus.cpu_boundary = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_db_rdata", bus.db_rdata, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_xfer_cnt", bus.xfer_cnt, 0);
        chk("rst_strobes", {bus.mem_we, bus.mem_re, bus.db1,
                            bus.db_ack, bus.cnt_wrap}, 0);
        chk("rst_bip", bus.break_in_prog, 0);
        chk("rst_late", bus.db_late, 0);
        reset = 1'b0;

        xfer(1'b0, 15'o12345, 12'o5252, '0, 0, 1'b0);
        chk("cnt_after_write", bus.xfer_cnt, 1);
        chk("mem_written", mem[15'o12345], 12'o5252);

        xfer(1'b0, 15'o00200, 12'o1234, '0, 0, 1'b0);
        b0 = bip_cnt;
        xfer(1'b1, 15'o00200, '0, 12'o1234, 0, 1'b0);
        chk("read_bip_clocks", bip_cnt - b0, 4);
        chk("read_db_rdata", bus.db_rdata, 12'o1234);

        xfer(1'b0, 15'o00300, 12'o7070, '0, 0, 1'b1);
        xfer(1'b1, 15'o12345, '0, 12'o5252, 0, 1'b0);
        chk("cnt_after_held", bus.xfer_cnt, exp_cnt);

        xfer(1'b0, 15'o04000, 12'o0001, '0, 10, 1'b0);
        chk("stall_late_after", bus.db_late, 0);

        xfer(1'b0, 15'o04001, 12'o0002, '0, -1, 1'b0);
        chk("timeout_late", bus.db_late, 1);
        chk("timeout_mem", mem[15'o04001], 12'o0002);

        @(posedge clk);
        #1;
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        exp_cnt = '0;
        chk("clear_cnt", bus.xfer_cnt, 0);
        chk("clear_late", bus.db_late, 0);

        w0 = wraps;
        for (int i = 0; i < 4096; i++)
            xfer(1'b0, 15'(i), ~12'(i), '0, 0, 1'b0);
        chk("wrap_cnt", bus.xfer_cnt, 0);
        chk("wrap_pulses", wraps - w0, 1);

        xfer(1'b0, 15'o05000, 12'o4321, '0, 0, 1'b0);
        chk("cnt_before_clear", bus.xfer_cnt, 1);

        // Read aborted by clear while waiting on memory.
        @(posedge clk);
        #1;
        bus.db_to_disk = 1'b1;
        bus.db_addr    = 15'o12345;
        bus.db_req     = 1'b1;
        m.we = 1'b0;
        m.re = 1'b1;
        m.a  = 15'o12345;
        m.d  = '0;
        mq.push_back(m);
        a0 = acks;
        repeat (3) @(posedge clk);
        #1;
        chk("wait_bip", bus.break_in_prog, 1);
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("clear_wait_no_ack", acks - a0, 0);
        chk("clear_wait_cnt", bus.xfer_cnt, 0);
        chk("clear_wait_bip", bus.break_in_prog, 0);
        bus.db_req = 1'b0;
        exp_cnt = '0;
        @(posedge clk);
        #1;

        xfer(1'b0, 15'o05001, 12'o1111, '0, 0, 1'b0);
        chk("cnt_before_reset", bus.xfer_cnt, 1);

        @(posedge clk);
        #1;
        bus.db_to_disk = 1'b0;
        bus.db_addr    = 15'o05002;
        bus.db_wdata   = 12'o2222;
        bus.db_req     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("cycle_we_pre", bus.mem_we, 1);
        reset = 1'b1;
        #1;
        chk("reset_we", bus.mem_we, 0);
        chk("reset_db1", bus.db1, 0);
        chk("reset_bip", bus.break_in_prog, 0);
        chk("reset_cnt", bus.xfer_cnt, 0);
        bus.db_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_cnt = '0;
        repeat (3) @(posedge clk);
        #1;

        chk("mq_empty", mq.size(), 0);
        chk("aq_empty", aq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
